// File: rtl/e8b10b_pkt_scheduler_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Package   : e8b10b_pkg
// Purpose   : Shared K-codes, counter widths and scheduler state encoding for
//             the 8b10b packet scheduler.
// Revision  : 1.0 - initial release
// ============================================================================
package e8b10b_pkg;

  // 9-bit encoder symbols; bit 8 set marks a K-code
  localparam logic [8:0] K_SOP = 9'h13C;
  localparam logic [8:0] K_EOP = 9'h1BC;

  // Idle cycles the encoder needs after K-end for CRC bytes and K28.5
  localparam int ENC_MIN_GAP = 6;

  // Payload byte counter width (covers the 1024-byte encoder limit)
  localparam int CNT_W = 11;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SOP  = 3'd1,
    DATA = 3'd2,
    EOP  = 3'd3,
    GAP  = 3'd4
  } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/e8b10b_pkt_scheduler_rr_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module    : rr_arbiter
// Purpose   : Combinational round-robin pick. Scans the request vector from
//             the pointer upward with wrap and returns the first hit as a
//             one-hot vector and as an index.
// Revision  : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  int w_pos;

  // First requester at or after the pointer (wrapping) wins
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_pos   = 0;
    for (int off = 0; off < N; off++) begin
      w_pos = int'(i_ptr) + off;
      if (w_pos >= N) begin
        w_pos = w_pos - N;
      end
      if (!o_any && i_req[w_pos]) begin
        o_any          = 1'b1;
        o_idx          = IDX_W'(w_pos);
        o_grant[w_pos] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/e8b10b_pkt_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module    : e8b10b_pkt_scheduler
// Purpose   : Shares one 8b10b framing encoder among N_REQ packet sources.
//             Grants round-robin at packet boundaries, frames each packet as
//             K-start / payload / K-end and enforces the encoder idle gap.
// Revision  : 1.0 - initial release
// ============================================================================
module e8b10b_pkt_scheduler
  import e8b10b_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int MAX_LEN = 1024,
  parameter int GAP_CYC = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_enable,
  input  logic [N_REQ-1:0]   i_req_valid,
  input  logic [N_REQ-1:0]   i_req_sop,
  input  logic [N_REQ-1:0]   i_req_eop,
  input  logic [8*N_REQ-1:0] i_req_data,
  output logic [N_REQ-1:0]   o_req_ready,
  output logic               o_pushin,
  output logic               o_startin,
  output logic [8:0]         o_datain,
  output logic [2:0]         o_grant_id,
  output logic               o_busy,
  output logic               o_err_underrun,
  output logic               o_err_overlen,
  output logic               o_err_framing
);

  localparam int IDX_W = $clog2(N_REQ);
  // A gap shorter than the encoder minimum would corrupt its CRC tail
  localparam int GAP_EFF = (GAP_CYC < ENC_MIN_GAP) ? ENC_MIN_GAP : GAP_CYC;
  localparam int GAP_W   = $clog2(GAP_EFF);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_EFF - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_LEN - 1);

  sched_state_t     r_state, w_state_nxt;
  logic [IDX_W-1:0] r_grant, w_grant_nxt;
  logic [N_REQ-1:0] r_grant_oh, w_grant_oh_nxt;
  logic [IDX_W-1:0] r_ptr, w_ptr_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [GAP_W-1:0] r_gap, w_gap_nxt;
  logic             r_pushin, w_push_nxt;
  logic             r_startin, w_start_nxt;
  logic [8:0]       r_datain, w_data_nxt;
  logic             r_err_und, w_und_nxt;
  logic             r_err_ovl, w_ovl_nxt;
  logic             r_err_frm, w_frm_nxt;
  logic [N_REQ-1:0] w_ready;

  logic [N_REQ-1:0] w_cand;
  logic [N_REQ-1:0] w_arb_oh;
  logic [IDX_W-1:0] w_arb_idx;
  logic             w_arb_any;
  logic             w_sel_valid;
  logic             w_sel_eop;
  logic [7:0]       w_sel_data;
  logic [IDX_W-1:0] w_ptr_adv;

  // Only ports presenting a first byte may start a packet
  assign w_cand = i_req_valid & i_req_sop;

  rr_arbiter #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .i_req   (w_cand),
    .i_ptr   (r_ptr),
    .o_grant (w_arb_oh),
    .o_idx   (w_arb_idx),
    .o_any   (w_arb_any)
  );

  // Byte lane of the granted requester; sop is irrelevant once granted
  assign w_sel_valid = |(i_req_valid & r_grant_oh);
  assign w_sel_eop   = |(i_req_eop & r_grant_oh);
  assign w_sel_data  = i_req_data[8*r_grant +: 8];
  assign w_ptr_adv   = (r_grant == IDX_W'(N_REQ - 1)) ? '0 : r_grant + 1'b1;

  // Next-state, next-output and ready generation
  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_grant_oh_nxt = r_grant_oh;
    w_ptr_nxt      = r_ptr;
    w_cnt_nxt      = r_cnt;
    w_gap_nxt      = r_gap;
    w_push_nxt     = 1'b0;
    w_start_nxt    = 1'b0;
    w_data_nxt     = '0;
    w_und_nxt      = 1'b0;
    w_ovl_nxt      = 1'b0;
    w_frm_nxt      = 1'b0;
    w_ready        = '0;
    unique case (r_state)
      IDLE: begin
        // Orphan mid-packet bytes are drained here and reported
        w_ready   = i_req_valid & ~i_req_sop;
        w_frm_nxt = |w_ready;
        if (i_enable && w_arb_any) begin
          w_grant_nxt    = w_arb_idx;
          w_grant_oh_nxt = w_arb_oh;
          w_state_nxt    = SOP;
        end
      end
      SOP: begin
        // The sop byte is held by the requester and taken in the first DATA cycle
        w_push_nxt  = 1'b1;
        w_start_nxt = 1'b1;
        w_data_nxt  = K_SOP;
        w_cnt_nxt   = '0;
        w_state_nxt = DATA;
      end
      DATA: begin
        w_ready = r_grant_oh;
        if (w_sel_valid) begin
          w_push_nxt = 1'b1;
          w_data_nxt = {1'b0, w_sel_data};
          w_cnt_nxt  = r_cnt + 1'b1;
          if (w_sel_eop) begin
            w_state_nxt = EOP;
          end else if (r_cnt == CNT_LAST) begin
            w_ovl_nxt   = 1'b1;
            w_state_nxt = EOP;
          end
        end else begin
          // Underrun: emit K-end right away so the encoder sees no bubble
          w_und_nxt   = 1'b1;
          w_push_nxt  = 1'b1;
          w_data_nxt  = K_EOP;
          w_ptr_nxt   = w_ptr_adv;
          w_gap_nxt   = GAP_LOAD;
          w_state_nxt = GAP;
        end
      end
      EOP: begin
        w_push_nxt  = 1'b1;
        w_data_nxt  = K_EOP;
        w_ptr_nxt   = w_ptr_adv;
        w_gap_nxt   = GAP_LOAD;
        w_state_nxt = GAP;
      end
      GAP: begin
        if (r_gap == '0) begin
          w_state_nxt = IDLE;
        end else begin
          w_gap_nxt = r_gap - 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Control state: FSM, grant, round-robin pointer, byte and gap counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_grant_oh <= '0;
      r_ptr      <= '0;
      r_cnt      <= '0;
      r_gap      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_grant_oh <= w_grant_oh_nxt;
      r_ptr      <= w_ptr_nxt;
      r_cnt      <= w_cnt_nxt;
      r_gap      <= w_gap_nxt;
    end
  end

  // Registered encoder interface and error pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pushin  <= 1'b0;
      r_startin <= 1'b0;
      r_datain  <= '0;
      r_err_und <= 1'b0;
      r_err_ovl <= 1'b0;
      r_err_frm <= 1'b0;
    end else begin
      r_pushin  <= w_push_nxt;
      r_startin <= w_start_nxt;
      r_datain  <= w_data_nxt;
      r_err_und <= w_und_nxt;
      r_err_ovl <= w_ovl_nxt;
      r_err_frm <= w_frm_nxt;
    end
  end

  assign o_req_ready    = w_ready;
  assign o_pushin       = r_pushin;
  assign o_startin      = r_startin;
  assign o_datain       = r_datain;
  assign o_grant_id     = 3'(r_grant);
  assign o_busy         = (r_state != IDLE);
  assign o_err_underrun = r_err_und;
  assign o_err_overlen  = r_err_ovl;
  assign o_err_framing  = r_err_frm;

endmodule
`default_nettype wire
